csr_encoder: RTL and testbench

CSR_ENCODER -- requirements
Module: csr_encoder

---
 rtl/csr_encoder_if.sv | 31 +++
 rtl/csr_encoder.sv | 140 ++++++++++++++
 tb/tb_csr_encoder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_encoder_if.sv
// Stream-in / CSR-write-out bundle for csr_encoder.
// The slave modport is the encoder; the master modport is whoever feeds the dense matrix.
interface csr_encoder_if;
    logic        start;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        sp_we;
    logic [13:0] sp_addr;
    logic [31:0] sp_wdata;
    logic [31:0] col_wdata;
    logic        row_we;
    logic [9:0]  row_addr;
    logic [31:0] row_wdata;
    logic [14:0] nnz;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, sp_we, sp_addr, sp_wdata, col_wdata,
               row_we, row_addr, row_wdata, nnz, busy, done, err
    );

    modport master (
        output start, in_data, in_valid,
        input  in_ready, sp_we, sp_addr, sp_wdata, col_wdata,
               row_we, row_addr, row_wdata, nnz, busy, done, err
    );
endinterface

// File: rtl/csr_encoder.sv
// Converts a row-major dense matrix stream into CSR form: value/column RAM writes per
// nonzero and a cumulative row-pointer write at the start of the frame and at the end of each row.
module csr_encoder #(
    parameter int N_ROWS  = 560,
    parameter int N_COLS  = 560,
    parameter int MAX_NNZ = 16384
) (
    input  logic         clk,
    input  logic         rst,
    csr_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    localparam logic [9:0]  LAST_COL = 10'(N_COLS - 1);
    localparam logic [9:0]  LAST_ROW = 10'(N_ROWS - 1);
    localparam logic [14:0] NNZ_CAP  = 15'(MAX_NNZ);

    state_t      r_state;
    logic [9:0]  r_col;
    logic [9:0]  r_row;
    logic [14:0] r_nnz;
    logic        r_err;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_sp_we;
    logic [13:0] r_sp_addr;
    logic [31:0] r_sp_wdata;
    logic [31:0] r_col_wdata;
    logic        r_row_we;
    logic [9:0]  r_row_addr;
    logic [31:0] r_row_wdata;

    logic w_hs;
    logic w_nonzero;
    logic w_store;
    logic w_last_col;
    logic w_last_row;

    // r_in_ready is only ever high in RUN, so it doubles as the state qualifier.
    assign w_hs       = bus.in_valid && r_in_ready;
    assign w_nonzero  = (bus.in_data != 32'd0);
    assign w_store    = w_nonzero && (r_nnz < NNZ_CAP);
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);

    // NOTE: all state below is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the write data/address registers are cleared too, not just the strobes,
            // so a reset leaves every output at a known zero.
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_nnz       <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sp_we     <= 1'b0;
            r_sp_addr   <= '0;
            r_sp_wdata  <= '0;
            r_col_wdata <= '0;
            r_row_we    <= 1'b0;
            r_row_addr  <= '0;
            r_row_wdata <= '0;
        end else begin
            r_sp_we  <= 1'b0;
            r_row_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state     <= INIT;
                        r_busy      <= 1'b1;
                        r_row_we    <= 1'b1;
                        r_row_addr  <= '0;
                        r_row_wdata <= '0;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_nnz       <= '0;
                        r_err       <= 1'b0;
                    end
                end
                INIT: begin
                    r_state    <= RUN;
                    r_in_ready <= 1'b1;
                end
                RUN: begin
                    if (w_hs) begin
                        if (w_store) begin
                            r_sp_we     <= 1'b1;
                            r_sp_addr   <= r_nnz[13:0];
                            r_sp_wdata  <= bus.in_data;
                            r_col_wdata <= {22'd0, r_col};
                            r_nnz       <= r_nnz + 15'd1;
                        end else if (w_nonzero) begin
                            r_err <= 1'b1;
                        end
                        // Row pointer for the next row counts the element just stored.
                        if (w_last_col) begin
                            r_col       <= '0;
                            r_row_we    <= 1'b1;
                            r_row_addr  <= r_row + 10'd1;
                            r_row_wdata <= {17'd0, r_nnz} + {31'd0, w_store};
                            if (w_last_row) begin
                                r_state    <= DONE;
                                r_in_ready <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_row <= r_row + 10'd1;
                            end
                        end else begin
                            r_col <= r_col + 10'd1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.sp_we     = r_sp_we;
    assign bus.sp_addr   = r_sp_addr;
    assign bus.sp_wdata  = r_sp_wdata;
    assign bus.col_wdata = r_col_wdata;
    assign bus.row_we    = r_row_we;
    assign bus.row_addr  = r_row_addr;
    assign bus.row_wdata = r_row_wdata;
    assign bus.nnz       = r_nnz;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_csr_encoder.sv
// Directed bench for csr_encoder: three instances (4x4, 3x3, 2x2 with MAX_NNZ=2)
// share clk/rst; a negedge monitor logs every RAM write and done pulse per instance.
module tb_csr_encoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  tb_start = '0;
    logic [2:0]  tb_valid = '0;
    logic [31:0] tb_data [3] = '{default: 32'd0};

    wire [2:0]  w_rdy, w_sp_we, w_row_we, w_busy, w_done, w_err;
    wire [13:0] w_sp_addr   [3];
    wire [31:0] w_sp_wdata  [3];
    wire [31:0] w_col_wdata [3];
    wire [9:0]  w_row_addr  [3];
    wire [31:0] w_row_wdata [3];
    wire [14:0] w_nnz       [3];

    int vectors = 0;
    int miscompares = 0;

    int          sp_n   [3] = '{0, 0, 0};
    int          row_n  [3] = '{0, 0, 0};
    int          done_n [3] = '{0, 0, 0};
    int          sp_a   [3][128];
    logic [31:0] sp_v   [3][128];
    logic [31:0] sp_c   [3][128];
    int          row_a  [3][128];
    logic [31:0] row_d  [3][128];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        csr_encoder_if bus ();
        assign bus.start    = tb_start[g];
        assign bus.in_data  = tb_data[g];
        assign bus.in_valid = tb_valid[g];
        assign w_rdy[g]       = bus.in_ready;
        assign w_sp_we[g]     = bus.sp_we;
        assign w_sp_addr[g]   = bus.sp_addr;
        assign w_sp_wdata[g]  = bus.sp_wdata;
        assign w_col_wdata[g] = bus.col_wdata;
        assign w_row_we[g]    = bus.row_we;
        assign w_row_addr[g]  = bus.row_addr;
        assign w_row_wdata[g] = bus.row_wdata;
        assign w_nnz[g]       = bus.nnz;
        assign w_busy[g]      = bus.busy;
        assign w_done[g]      = bus.done;
        assign w_err[g]       = bus.err;

        csr_encoder #(
            .N_ROWS (g == 0 ? 4 : (g == 1 ? 3 : 2)),
            .N_COLS (g == 0 ? 4 : (g == 1 ? 3 : 2)),
            .MAX_NNZ(g == 2 ? 2 : 16384)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (w_sp_we[k] && sp_n[k] < 128) begin
                sp_a[k][sp_n[k]] <= int'(w_sp_addr[k]);
                sp_v[k][sp_n[k]] <= w_sp_wdata[k];
                sp_c[k][sp_n[k]] <= w_col_wdata[k];
                sp_n[k]          <= sp_n[k] + 1;
            end
            if (w_row_we[k] && row_n[k] < 128) begin
                row_a[k][row_n[k]] <= int'(w_row_addr[k]);
                row_d[k][row_n[k]] <= w_row_wdata[k];
                row_n[k]           <= row_n[k] + 1;
            end
            if (w_done[k]) done_n[k] <= done_n[k] + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start(input int k);
        @(negedge clk);
        tb_start[k] = 1'b1;
        @(negedge clk);
        tb_start[k] = 1'b0;
    endtask

    // Presents m[first..last]; a set bit in gaps drops in_valid for 1-3 cycles before that element.
    task automatic stream(input int k, input int first, input int last,
                          input logic [31:0] m [16], input logic [15:0] gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps[i]) begin
                tb_valid[k] = 1'b0;
                repeat ((i % 3) + 1) @(negedge clk);
            end
            tb_valid[k] = 1'b1;
            tb_data[k]  = m[i];
            for (int t = 0; t < 50 && !w_rdy[k]; t++) @(negedge clk);
            if (!w_rdy[k]) begin
                vectors++; miscompares++;
                $display("FAIL stream_ready inst=%0d elem=%0d: in_ready got 0 want 1 within 50 cycles", k, i);
            end
            @(negedge clk);
        end
        tb_valid[k] = 1'b0;
        tb_data[k]  = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({w_rdy[k], w_sp_we[k], w_row_we[k], w_busy[k], w_done[k], w_err[k]} !== 6'b0 ||
                w_nnz[k] !== 15'd0) begin
                miscompares++;
                $display("FAIL reset_state inst=%0d: rdy/spwe/rowwe/busy/done/err got %b nnz %0d want 000000 nnz 0",
                         k, {w_rdy[k], w_sp_we[k], w_row_we[k], w_busy[k], w_done[k], w_err[k]}, w_nnz[k]);
            end
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (w_busy !== 3'b000 || w_rdy !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release: busy got %b rdy got %b want 000/000", w_busy, w_rdy);
        end
    endtask

    task automatic test_identity();
        logic [31:0] m [16];
        int sb, rb, db;
        for (int i = 0; i < 16; i++) m[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
        sb = sp_n[0]; rb = row_n[0]; db = done_n[0];
        do_start(0);
        stream(0, 0, 15, m, 16'h0000);
        repeat (3) @(negedge clk);
        vectors++;
        if (sp_n[0] - sb !== 4 || row_n[0] - rb !== 5 || done_n[0] - db !== 1) begin
            miscompares++;
            $display("FAIL identity_counts: sp %0d row %0d done %0d want 4 5 1",
                     sp_n[0] - sb, row_n[0] - rb, done_n[0] - db);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (sp_a[0][sb+i] !== i || sp_v[0][sb+i] !== 32'd1 || sp_c[0][sb+i] !== 32'(i)) begin
                miscompares++;
                $display("FAIL identity_sp[%0d]: addr/val/col got %0d/%0d/%0d want %0d/1/%0d",
                         i, sp_a[0][sb+i], sp_v[0][sb+i], sp_c[0][sb+i], i, i);
            end
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (row_a[0][rb+i] !== i || row_d[0][rb+i] !== 32'(i)) begin
                miscompares++;
                $display("FAIL identity_rowptr[%0d]: addr/data got %0d/%0d want %0d/%0d",
                         i, row_a[0][rb+i], row_d[0][rb+i], i, i);
            end
        end
        vectors++;
        if (w_nnz[0] !== 15'd4 || w_busy[0] !== 1'b0 || w_err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL identity_final: nnz/busy/err got %0d/%b/%b want 4/0/0", w_nnz[0], w_busy[0], w_err[0]);
        end
    endtask

    task automatic test_idle_ignored();
        int sb, rb;
        sb = sp_n[0]; rb = row_n[0];
        tb_valid[0] = 1'b1;
        tb_data[0]  = 32'h0000_00ab;
        repeat (5) @(negedge clk);
        vectors++;
        if (w_rdy[0] !== 1'b0 || w_busy[0] !== 1'b0 || w_nnz[0] !== 15'd4) begin
            miscompares++;
            $display("FAIL idle_hold: rdy/busy/nnz got %b/%b/%0d want 0/0/4", w_rdy[0], w_busy[0], w_nnz[0]);
        end
        tb_valid[0] = 1'b0;
        tb_data[0]  = 32'd0;
        @(negedge clk);
        vectors++;
        if (sp_n[0] !== sb || row_n[0] !== rb) begin
            miscompares++;
            $display("FAIL idle_writes: sp/row writes got %0d/%0d want 0/0", sp_n[0] - sb, row_n[0] - rb);
        end
    endtask

    task automatic test_all_zero();
        logic [31:0] m [16];
        int sb, rb, db;
        m = '{default: 32'd0};
        sb = sp_n[0]; rb = row_n[0]; db = done_n[0];
        do_start(0);
        stream(0, 0, 15, m, 16'h0000);
        repeat (3) @(negedge clk);
        vectors++;
        if (sp_n[0] - sb !== 0 || row_n[0] - rb !== 5 || done_n[0] - db !== 1 || w_nnz[0] !== 15'd0) begin
            miscompares++;
            $display("FAIL zero_counts: sp %0d row %0d done %0d nnz %0d want 0 5 1 0",
                     sp_n[0] - sb, row_n[0] - rb, done_n[0] - db, w_nnz[0]);
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (row_a[0][rb+i] !== i || row_d[0][rb+i] !== 32'd0) begin
                miscompares++;
                $display("FAIL zero_rowptr[%0d]: addr/data got %0d/%0d want %0d/0",
                         i, row_a[0][rb+i], row_d[0][rb+i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] m [16];
        int sb, rb, db;
        int          exp_col [3] = '{1, 0, 2};
        logic [31:0] exp_val [3] = '{32'd5, 32'd7, 32'd9};
        int          exp_ptr [4] = '{0, 1, 3, 3};
        m = '{default: 32'd0};
        m[1] = 32'd5; m[3] = 32'd7; m[5] = 32'd9;
        sb = sp_n[1]; rb = row_n[1]; db = done_n[1];
        do_start(1);
        stream(1, 0, 8, m, 16'b0000_0001_0110_0101);
        repeat (3) @(negedge clk);
        vectors++;
        if (sp_n[1] - sb !== 3 || row_n[1] - rb !== 4 || done_n[1] - db !== 1) begin
            miscompares++;
            $display("FAIL bp_counts: sp %0d row %0d done %0d want 3 4 1",
                     sp_n[1] - sb, row_n[1] - rb, done_n[1] - db);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (sp_a[1][sb+i] !== i || sp_v[1][sb+i] !== exp_val[i] || sp_c[1][sb+i] !== 32'(exp_col[i])) begin
                miscompares++;
                $display("FAIL bp_sp[%0d]: addr/val/col got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, sp_a[1][sb+i], sp_v[1][sb+i], sp_c[1][sb+i], i, exp_val[i], exp_col[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (row_a[1][rb+i] !== i || row_d[1][rb+i] !== 32'(exp_ptr[i])) begin
                miscompares++;
                $display("FAIL bp_rowptr[%0d]: addr/data got %0d/%0d want %0d/%0d",
                         i, row_a[1][rb+i], row_d[1][rb+i], i, exp_ptr[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] m [16];
        int sb, rb, db;
        int exp_ptr [3] = '{0, 2, 2};
        m = '{default: 32'd1};
        sb = sp_n[2]; rb = row_n[2]; db = done_n[2];
        do_start(2);
        stream(2, 0, 1, m, 16'h0000);
        vectors++;
        if (w_err[2] !== 1'b0 || w_nnz[2] !== 15'd2) begin
            miscompares++;
            $display("FAIL ovf_before: err/nnz got %b/%0d want 0/2", w_err[2], w_nnz[2]);
        end
        stream(2, 2, 2, m, 16'h0000);
        vectors++;
        if (w_err[2] !== 1'b1 || w_nnz[2] !== 15'd2 || w_sp_we[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_third: err/nnz/sp_we got %b/%0d/%b want 1/2/0", w_err[2], w_nnz[2], w_sp_we[2]);
        end
        stream(2, 3, 3, m, 16'h0000);
        repeat (3) @(negedge clk);
        vectors++;
        if (sp_n[2] - sb !== 2 || row_n[2] - rb !== 3 || done_n[2] - db !== 1 ||
            w_err[2] !== 1'b1 || w_nnz[2] !== 15'd2) begin
            miscompares++;
            $display("FAIL ovf_final: sp %0d row %0d done %0d err %b nnz %0d want 2 3 1 1 2",
                     sp_n[2] - sb, row_n[2] - rb, done_n[2] - db, w_err[2], w_nnz[2]);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (sp_a[2][sb+i] !== i || sp_v[2][sb+i] !== 32'd1 || sp_c[2][sb+i] !== 32'(i)) begin
                miscompares++;
                $display("FAIL ovf_sp[%0d]: addr/val/col got %0d/%0d/%0d want %0d/1/%0d",
                         i, sp_a[2][sb+i], sp_v[2][sb+i], sp_c[2][sb+i], i, i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (row_a[2][rb+i] !== i || row_d[2][rb+i] !== 32'(exp_ptr[i])) begin
                miscompares++;
                $display("FAIL ovf_rowptr[%0d]: addr/data got %0d/%0d want %0d/%0d",
                         i, row_a[2][rb+i], row_d[2][rb+i], i, exp_ptr[i]);
            end
        end
    endtask

    // Full 4x4 frame of values 1..16 checked against what a fresh encode must produce.
    task automatic test_reset_mid_frame();
        logic [31:0] m [16];
        int sb, rb, db;
        for (int i = 0; i < 16; i++) m[i] = 32'(i + 1);
        do_start(0);
        stream(0, 0, 4, m, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({w_rdy[0], w_sp_we[0], w_row_we[0], w_busy[0], w_done[0], w_err[0]} !== 6'b0 ||
            w_nnz[0] !== 15'd0 || w_sp_addr[0] !== 14'd0 || w_row_addr[0] !== 10'd0 ||
            w_sp_wdata[0] !== 32'd0 || w_col_wdata[0] !== 32'd0 || w_row_wdata[0] !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: flags %b nnz %0d spa %0d rowa %0d spd %0d cold %0d rowd %0d want all 0",
                     {w_rdy[0], w_sp_we[0], w_row_we[0], w_busy[0], w_done[0], w_err[0]}, w_nnz[0],
                     w_sp_addr[0], w_row_addr[0], w_sp_wdata[0], w_col_wdata[0], w_row_wdata[0]);
        end
        rst = 1'b1;
        sb = sp_n[0]; rb = row_n[0];
        tb_valid[0] = 1'b1;
        tb_data[0]  = 32'd77;
        repeat (4) @(negedge clk);
        tb_valid[0] = 1'b0;
        tb_data[0]  = 32'd0;
        @(negedge clk);
        vectors++;
        if (sp_n[0] !== sb || row_n[0] !== rb || w_nnz[0] !== 15'd0) begin
            miscompares++;
            $display("FAIL midreset_abandon: sp/row writes %0d/%0d nnz %0d want 0/0/0",
                     sp_n[0] - sb, row_n[0] - rb, w_nnz[0]);
        end
        sb = sp_n[0]; rb = row_n[0]; db = done_n[0];
        do_start(0);
        stream(0, 0, 15, m, 16'h0000);
        repeat (3) @(negedge clk);
        vectors++;
        if (sp_n[0] - sb !== 16 || row_n[0] - rb !== 5 || done_n[0] - db !== 1 || w_nnz[0] !== 15'd16) begin
            miscompares++;
            $display("FAIL midreset_reencode: sp %0d row %0d done %0d nnz %0d want 16 5 1 16",
                     sp_n[0] - sb, row_n[0] - rb, done_n[0] - db, w_nnz[0]);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (sp_a[0][sb+i] !== i || sp_v[0][sb+i] !== 32'(i + 1) || sp_c[0][sb+i] !== 32'(i % 4)) begin
                miscompares++;
                $display("FAIL midreset_sp[%0d]: addr/val/col got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, sp_a[0][sb+i], sp_v[0][sb+i], sp_c[0][sb+i], i, i + 1, i % 4);
            end
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (row_a[0][rb+i] !== i || row_d[0][rb+i] !== 32'(4 * i)) begin
                miscompares++;
                $display("FAIL midreset_rowptr[%0d]: addr/data got %0d/%0d want %0d/%0d",
                         i, row_a[0][rb+i], row_d[0][rb+i], i, 4 * i);
            end
        end
    endtask

    task automatic test_start_during_run();
        logic [31:0] m [16];
        int sb, rb, db;
        for (int i = 0; i < 16; i++) m[i] = 32'(i + 1);
        sb = sp_n[0]; rb = row_n[0]; db = done_n[0];
        do_start(0);
        stream(0, 0, 5, m, 16'h0000);
        do_start(0);
        @(negedge clk);
        vectors++;
        if (w_nnz[0] !== 15'd6 || w_busy[0] !== 1'b1 || w_rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL run_start_ignored: nnz/busy/rdy got %0d/%b/%b want 6/1/1", w_nnz[0], w_busy[0], w_rdy[0]);
        end
        stream(0, 6, 15, m, 16'h0000);
        repeat (3) @(negedge clk);
        vectors++;
        if (sp_n[0] - sb !== 16 || row_n[0] - rb !== 5 || done_n[0] - db !== 1 || w_nnz[0] !== 15'd16) begin
            miscompares++;
            $display("FAIL run_start_counts: sp %0d row %0d done %0d nnz %0d want 16 5 1 16",
                     sp_n[0] - sb, row_n[0] - rb, done_n[0] - db, w_nnz[0]);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (sp_a[0][sb+i] !== i || sp_c[0][sb+i] !== 32'(i % 4)) begin
                miscompares++;
                $display("FAIL run_start_sp[%0d]: addr/col got %0d/%0d want %0d/%0d",
                         i, sp_a[0][sb+i], sp_c[0][sb+i], i, i % 4);
            end
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (row_a[0][rb+i] !== i || row_d[0][rb+i] !== 32'(4 * i)) begin
                miscompares++;
                $display("FAIL run_start_rowptr[%0d]: addr/data got %0d/%0d want %0d/%0d",
                         i, row_a[0][rb+i], row_d[0][rb+i], i, 4 * i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_idle_ignored();
        test_all_zero();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
        test_start_during_run();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
